// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator front end.
package calc_pkg;
    localparam int NUM_PB        = 13;
    localparam int DEBOUNCE_SIM  = 4;
    localparam int DEBOUNCE_FPGA = 100000;
    localparam int PB_DIG0       = 0;
    localparam int PB_DIG1       = 1;
    localparam int PB_OP_LO      = 10;
    localparam int PB_OP_HI      = 12;
    localparam int PB_IDX_W      = $clog2(NUM_PB);
endpackage

// File: rtl/pb_conditioner_if.sv
// pb_conditioner_if: raw buttons in, conditioned levels, strobes and key event out.
interface pb_conditioner_if #(parameter int N = calc_pkg::NUM_PB) ();
    logic [N-1:0]         pb_raw;
    logic [N-1:0]         pb_level;
    logic [N-1:0]         pb_strobe;
    logic                 strobe_valid;
    logic [$clog2(N)-1:0] strobe_idx;
    logic                 multi_press;
    modport master (output pb_raw, input pb_level, pb_strobe, strobe_valid, strobe_idx, multi_press);
    modport slave  (input pb_raw, output pb_level, pb_strobe, strobe_valid, strobe_idx, multi_press);
endinterface

// File: rtl/pb_debounce_bit.sv
// pb_debounce_bit: two-flop synchroniser, debounce counter, level and press strobe for one button.
module pb_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw_i,
    output logic pb_level_o,
    output logic pb_strobe_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic          sync1_q, sync2_q, level_q, strobe_q;
    logic          level_d, strobe_d, done;
    logic [CW-1:0] cnt_q, cnt_d;
    // the compare against CNT_MAX bounds the counter, so it never wraps
    always_comb begin
        done     = (sync2_q != level_q) && (cnt_q == CNT_MAX);
        cnt_d    = (sync2_q == level_q || done) ? '0 : cnt_q + CW'(1);
        level_d  = done ? sync2_q : level_q;
        strobe_d = done && sync2_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pb_raw_i;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end
    assign pb_level_o  = level_q;
    assign pb_strobe_o = strobe_q;
endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: per-button debounce plus priority encode of the press strobes.
module pb_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input logic             clk,
    input logic             rst,
    pb_conditioner_if.slave pb
);
    logic [NUM_PB-1:0]   level_w, strobe_w;
    logic [PB_IDX_W-1:0] idx_c;
    for (genvar i = 0; i < NUM_PB; i++) begin : g_bit
        pb_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
            .clk        (clk),
            .rst        (rst),
            .pb_raw_i   (pb.pb_raw[i]),
            .pb_level_o (level_w[i]),
            .pb_strobe_o(strobe_w[i])
        );
    end
    // scan from the top so the lowest set strobe ends up winning
    always_comb begin
        idx_c = '0;
        for (int i = NUM_PB - 1; i >= 0; i--)
            idx_c = strobe_w[i] ? PB_IDX_W'(i) : idx_c;
    end
    assign pb.pb_level     = level_w;
    assign pb.pb_strobe    = strobe_w;
    assign pb.strobe_valid = |strobe_w;
    assign pb.strobe_idx   = idx_c;
    assign pb.multi_press  = $countones(strobe_w) > 1;
endmodule
